// File: rtl/fft_pkg.sv
// Shared FFT definitions: default sizes, bank mapping, bit reversal
// and the read-out FSM state type.
package fft_pkg;

  localparam int FFT_N_LOG2 = 6;
  localparam int FFT_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } fsm_state_e;

  // Bank holding logical address a: parity of all its bits.
  function automatic logic bank_of(
    input logic [FFT_N_LOG2-1:0] a
  );
    return ^a;
  endfunction

  function automatic logic [FFT_N_LOG2-1:0] bitrev(
    input logic [FFT_N_LOG2-1:0] a
  );
    logic [FFT_N_LOG2-1:0] r;
    for (int i = 0; i < FFT_N_LOG2; i++) begin
      r[i] = a[FFT_N_LOG2-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_output_unloader_if.sv
// Bank read ports plus the output valid/ready stream.
// master: unloader side; slave: SRAM banks + consumer side.
interface fft_output_unloader_if #(
  parameter int N_LOG2 = fft_pkg::FFT_N_LOG2,
  parameter int DATA_W = fft_pkg::FFT_DATA_W
);

  logic              re_b0;
  logic              re_b1;
  logic [N_LOG2-2:0] raddr_b0;
  logic [N_LOG2-2:0] raddr_b1;
  logic [DATA_W-1:0] rdata_b0;
  logic [DATA_W-1:0] rdata_b1;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [N_LOG2-1:0] out_index;
  logic              out_last;

  modport master (
    output re_b0, re_b1, raddr_b0, raddr_b1,
    input  rdata_b0, rdata_b1,
    output out_valid, out_data, out_index,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  re_b0, re_b1, raddr_b0, raddr_b1,
    output rdata_b0, rdata_b1,
    input  out_valid, out_data, out_index,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/fft_out_fifo.sv
// Small synchronous FIFO for returning bank data.
// Ports: clk, rst, clr, push/wdata, pop/rdata, full, empty, count.
module fft_out_fifo #(
  parameter int DEPTH = 3,
  parameter int W     = 38
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         push,
  input  logic [W-1:0]                 wdata,
  input  logic                         pop,
  output logic [W-1:0]                 rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Empty head reads as zero so idle outputs stay clean.
  assign rdata   = empty ? '0 : mem_q[rd_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (clr) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= inc(wr_q);
      if (do_pop)  rd_q <= inc(rd_q);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata;
  end

endmodule

// File: rtl/fft_output_unloader.sv
// Streams the 64-point FFT result out of the two SRAM banks.
// Ports: clk, rst, start, busy, done, bus (bank reads + output stream).
// FFT_UNLOAD_BITREV_EN: emit bins in natural order (a = bitrev(k)).
module fft_output_unloader
  import fft_pkg::*;
#(
  parameter int N_LOG2 = FFT_N_LOG2,
  parameter int DATA_W = FFT_DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  fft_output_unloader_if.master bus
);

  localparam int N     = 1 << N_LOG2;
  localparam int DEPTH = RD_LAT + 2;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int FW    = N_LOG2 + DATA_W;

  fsm_state_e state_q, state_d;
  logic [N_LOG2:0] k_rd_q, k_rd_d;
  logic [N_LOG2:0] k_out_q, k_out_d;
  logic            done_q, done_d;

  // Read pipe: valid, bank and bin index travel with each read.
  logic [RD_LAT-1:0]             pv_q, pb_q;
  logic [RD_LAT-1:0][N_LOG2-1:0] pi_q;

  logic [N_LOG2-1:0] addr;
  logic              bank, issue, pop, clr;
  logic              full, empty;
  logic [CW-1:0]     occ, infl;
  logic [FW-1:0]     wdata, head;

  always_comb begin
`ifdef FFT_UNLOAD_BITREV_EN
    addr = bitrev(k_rd_q[N_LOG2-1:0]);
`else
    addr = k_rd_q[N_LOG2-1:0];
`endif
  end

  always_comb begin
    infl = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      infl = infl + CW'(pv_q[i]);
    end
  end

  // Credit: in-flight reads plus buffered data never exceed the FIFO.
  assign bank  = bank_of(addr);
  assign issue = (state_q == READ) && !full &&
                 ((int'(infl) + int'(occ)) < DEPTH);

  assign bus.re_b0    = issue && !bank;
  assign bus.re_b1    = issue && bank;
  assign bus.raddr_b0 = bus.re_b0 ? addr[N_LOG2-1:1] : '0;
  assign bus.raddr_b1 = bus.re_b1 ? addr[N_LOG2-1:1] : '0;

  assign wdata = {pi_q[RD_LAT-1],
                  pb_q[RD_LAT-1] ? bus.rdata_b1 : bus.rdata_b0};

  fft_out_fifo #(
    .DEPTH (DEPTH),
    .W     (FW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (pv_q[RD_LAT-1]),
    .wdata (wdata),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (occ)
  );

  assign bus.out_valid = !empty;
  assign bus.out_data  = head[DATA_W-1:0];
  assign bus.out_index = head[FW-1:DATA_W];
  assign bus.out_last  = !empty &&
                         (head[FW-1:DATA_W] == N_LOG2'(N - 1));
  assign pop  = bus.out_valid && bus.out_ready;
  assign busy = (state_q != IDLE);
  assign done = done_q;

  always_comb begin
    state_d = state_q;
    k_rd_d  = k_rd_q;
    k_out_d = pop ? k_out_q + 1'b1 : k_out_q;
    done_d  = 1'b0;
    clr     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = READ;
          k_rd_d  = '0;
          k_out_d = '0;
          clr     = 1'b1;
        end
      end
      READ: begin
        if (issue) begin
          k_rd_d = k_rd_q + 1'b1;
          if (k_rd_q == (N_LOG2+1)'(N - 1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && k_out_q == (N_LOG2+1)'(N - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_rd_q  <= '0;
      k_out_q <= '0;
      done_q  <= 1'b0;
      pv_q    <= '0;
      pb_q    <= '0;
      pi_q    <= '0;
    end else begin
      state_q <= state_d;
      k_rd_q  <= k_rd_d;
      k_out_q <= k_out_d;
      done_q  <= done_d;
      pv_q[0] <= issue;
      pb_q[0] <= bank;
      pi_q[0] <= k_rd_q[N_LOG2-1:0];
      for (int i = 1; i < RD_LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        pb_q[i] <= pb_q[i-1];
        pi_q[i] <= pi_q[i-1];
      end
    end
  end

endmodule

// File: tb/tb_fft_output_unloader.sv
// Bench for fft_output_unloader: SRAM bank model, stream scoreboard,
// directed frames (full rate, stall, random ready, abort, restart).
module tb_fft_output_unloader;

  localparam int NL  = 6;
  localparam int DW  = 32;
  localparam int LAT = 3;
  localparam int N   = 1 << NL;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic start = 1'b0;
  logic busy, done;

  fft_output_unloader_if #(.N_LOG2(NL), .DATA_W(DW)) bus ();

  fft_output_unloader #(
    .N_LOG2 (NL),
    .DATA_W (DW),
    .RD_LAT (LAT)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // ---- specification model ----
  function automatic int brev(input int k);
    int r = 0;
    for (int i = 0; i < NL; i++)
      if ((k >> i) & 1) r |= 1 << (NL - 1 - i);
    return r;
  endfunction

  function automatic int addr_of(input int k);
`ifdef FFT_UNLOAD_BITREV_EN
    return brev(k);
`else
    return k;
`endif
  endfunction

  function automatic int bank(input int a);
    return $countones(a) & 1;
  endfunction

  function automatic logic [DW-1:0] word_of(input int a);
    logic [15:0] x;
    x = a[15:0];
    return {x, ~x};
  endfunction

  // ---- SRAM banks with LAT-cycle read latency ----
  logic [DW-1:0] m0 [N/2];
  logic [DW-1:0] m1 [N/2];
  logic [DW-1:0] d0 [LAT];
  logic [DW-1:0] d1 [LAT];

  initial begin
    for (int a = 0; a < N; a++) begin
      if (bank(a) != 0) m1[a/2] = word_of(a);
      else              m0[a/2] = word_of(a);
    end
  end

  always @(posedge clk) begin
    d0[0] <= bus.re_b0 ? m0[bus.raddr_b0] : 32'hDEAD0000;
    d1[0] <= bus.re_b1 ? m1[bus.raddr_b1] : 32'hBEEF0000;
    for (int i = 1; i < LAT; i++) begin
      d0[i] <= d0[i-1];
      d1[i] <= d1[i-1];
    end
  end

  assign bus.rdata_b0 = d0[LAT-1];
  assign bus.rdata_b1 = d1[LAT-1];

  // ---- consumer ready: 0 hold low, 1 hold high, 2 random ----
  int rmode = 1;
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0:       bus.out_ready = 1'b0;
        1:       bus.out_ready = 1'b1;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---- compare process ----
  int gen = 0, seen_gen = 0;
  int exp_k = 0, rd_n = 0, n_done = 0;
  int ma, mb;
  logic [DW-1:0] got_d [N];
  int rd_bank [N];
  int rd_word [N];
  logic          hold_q = 1'b0;
  logic [DW-1:0] hold_d;
  logic [NL-1:0] hold_i;

  always @(negedge clk) begin
    if (gen != seen_gen) begin
      seen_gen = gen;
      exp_k    = 0;
      rd_n     = 0;
      n_done   = 0;
      hold_q   = 1'b0;
    end
    if (rst) begin
      hold_q = 1'b0;
    end else begin
      if (hold_q) begin
        check("hold_valid", bus.out_valid, 1);
        check("hold_data", bus.out_data, hold_d);
        check("hold_index", bus.out_index, hold_i);
      end
      if (bus.re_b0 || bus.re_b1) begin
        if (rd_n >= N) begin
          check("extra_read", rd_n, N - 1);
        end else begin
          ma = addr_of(rd_n);
          mb = bank(ma);
          check("re_sel", {bus.re_b0, bus.re_b1},
                (mb != 0) ? 2'b01 : 2'b10);
          check("raddr",
                (mb != 0) ? bus.raddr_b1 : bus.raddr_b0, ma / 2);
          check("raddr_other",
                (mb != 0) ? bus.raddr_b0 : bus.raddr_b1, 0);
          rd_bank[rd_n] = bus.re_b1 ? 1 : 0;
          rd_word[rd_n] = bus.re_b1 ? int'(bus.raddr_b1)
                                    : int'(bus.raddr_b0);
        end
        rd_n++;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_k >= N) begin
          check("extra_beat", exp_k, N - 1);
        end else begin
          check("index", bus.out_index, exp_k);
          check("data", bus.out_data, word_of(addr_of(exp_k)));
          check("last", bus.out_last, exp_k == N - 1);
          got_d[exp_k] = bus.out_data;
          exp_k++;
        end
      end
      if (done) n_done++;
      hold_q = bus.out_valid && !bus.out_ready;
      hold_d = bus.out_data;
      hold_i = bus.out_index;
    end
  end

  // ---- sequencing ----
  task automatic nwait();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start(output int s);
    gen++;
    @(posedge clk);
    #1;
    start = 1'b1;
    s     = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic watch(input int maxc, output int t_re,
                       output int t_v, output int t_d,
                       output int busy_bad);
    t_re = -1; t_v = -1; t_d = -1; busy_bad = 0;
    for (int i = 0; i < maxc; i++) begin
      nwait();
      if (t_re < 0 && (bus.re_b0 || bus.re_b1)) t_re = cyc;
      if (t_v < 0 && bus.out_valid) t_v = cyc;
      if (done) begin
        t_d = cyc;
        if (busy) busy_bad = 1;
        break;
      end
      if (!busy) busy_bad = 1;
    end
    if (t_d < 0) check("done_timeout", 0, 1);
  endtask

  task automatic wait_beats(input int nb);
    int i;
    for (i = 0; i < 500 && exp_k < nb; i++) nwait();
    if (exp_k < nb) check("beat_timeout", exp_k, nb);
  endtask

  task automatic frame_end(input string nm, input int busy_bad);
    check({nm, "_beats"}, exp_k, N);
    check({nm, "_done_pulses"}, n_done, 1);
    check({nm, "_busy"}, busy_bad, 0);
  endtask

  initial begin
    int s, t_re, t_v, t_d, bb;

    repeat (3) @(posedge clk);
    nwait();
    check("reset_outs",
          {busy, done, bus.re_b0, bus.re_b1, bus.raddr_b0,
           bus.raddr_b1, bus.out_valid, bus.out_data,
           bus.out_index, bus.out_last}, 0);
    rst = 1'b0;
    repeat (2) nwait();

    // Full-rate frame
    rmode = 1;
    pulse_start(s);
    watch(300, t_re, t_v, t_d, bb);
    check("first_re", t_re - s, 1);
    check("first_valid", t_v - s, LAT + 2);
    check("done_cycle", t_d - s, N + LAT + 2);
    frame_end("full", bb);
`ifdef FFT_UNLOAD_BITREV_EN
    check("bin1_data", got_d[1], 32'h0020FFDF);
    check("bin5_data", got_d[5], 32'h0028FFD7);
    check("k1_bank", rd_bank[1], 1);
    check("k1_word", rd_word[1], 16);
    check("k3_bank", rd_bank[3], 0);
    check("k3_word", rd_word[3], 24);
`else
    check("bin1_data", got_d[1], 32'h0001FFFE);
    check("bin5_data", got_d[5], 32'h0005FFFA);
    check("k1_bank", rd_bank[1], 1);
    check("k1_word", rd_word[1], 0);
    check("k3_bank", rd_bank[3], 0);
    check("k3_word", rd_word[3], 1);
`endif
    check("bin63_data", got_d[63], 32'h003FFFC0);
    repeat (3) nwait();

    // Consumer stalled for 20 cycles
    rmode = 0;
    pulse_start(s);
    repeat (20) nwait();
    check("stall_reads", rd_n, LAT + 2);
    check("stall_valid", bus.out_valid, 1);
    check("stall_index", bus.out_index, 0);
    rmode = 1;
    nwait();
    check("re_before_pop", bus.re_b0 | bus.re_b1, 0);
    nwait();
    check("re_after_pop", bus.re_b0 | bus.re_b1, 1);
    watch(400, t_re, t_v, t_d, bb);
    frame_end("stall", bb);
    repeat (3) nwait();

    // Random backpressure, then a start in the done cycle
    rmode = 2;
    pulse_start(s);
    watch(2000, t_re, t_v, t_d, bb);
    frame_end("random", bb);
    rmode = 1;
    gen++;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    nwait();
    check("start_on_done", {busy, bus.re_b0 | bus.re_b1}, 2'b11);
    watch(300, t_re, t_v, t_d, bb);
    frame_end("back2back", bb);
    repeat (3) nwait();

    // Abort by reset at k_out = 10
    pulse_start(s);
    wait_beats(10);
    rst = 1'b1;
    #1;
    check("abort_outs",
          {busy, done, bus.re_b0, bus.re_b1, bus.raddr_b0,
           bus.raddr_b1, bus.out_valid, bus.out_data,
           bus.out_index, bus.out_last}, 0);
    repeat (2) nwait();
    rst = 1'b0;
    repeat (5) nwait();
    check("abort_idle", {busy, bus.out_valid, done}, 0);
    check("abort_no_done", n_done, 0);
    pulse_start(s);
    watch(300, t_re, t_v, t_d, bb);
    check("restart_done_cycle", t_d - s, N + LAT + 2);
    frame_end("restart", bb);
    repeat (3) nwait();

    // Start while busy at k_out = 30 is ignored
    pulse_start(s);
    wait_beats(30);
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    watch(300, t_re, t_v, t_d, bb);
    frame_end("ignored", bb);
    repeat (10) nwait();
    check("ignored_idle", busy, 0);
    check("ignored_reads", rd_n, N);
    check("ignored_single_done", n_done, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

endmodule
